// File: rtl/way_line_feeder_if.sv
// Line-feeder bus: the filler's empty flags, the upstream line source handshake,
// and the write port into the filler's per-way line buffers.
interface way_line_feeder_if #(
  parameter int W_LOG = 2,
  parameter int P_LOG = 3,
  parameter int DATW  = 64
);
  localparam int WAYS  = 1 << W_LOG;
  localparam int LINEW = DATW << P_LOG;

  logic [WAYS-1:0]  EMP;
  logic             SRC_REQ;
  logic [W_LOG-1:0] SRC_REQ_WAY;
  logic             SRC_RDY;
  logic [LINEW-1:0] SRC_DIN;
  logic             SRC_DINEN;
  logic [LINEW-1:0] DOT;
  logic             DOTEN;
  logic [W_LOG-1:0] WADDR;
  logic             DONE;

  modport master (
    input  EMP, SRC_RDY, SRC_DIN, SRC_DINEN,
    output SRC_REQ, SRC_REQ_WAY, DOT, DOTEN, WADDR, DONE
  );

  modport slave (
    output EMP, SRC_RDY, SRC_DIN, SRC_DINEN,
    input  SRC_REQ, SRC_REQ_WAY, DOT, DOTEN, WADDR, DONE
  );
endinterface

// File: rtl/way_line_feeder.sv
// Refills the tree filler's empty way buffers round-robin from an upstream line
// source; ways that have delivered their full run get all-ones sentinel lines.
module way_line_feeder #(
  parameter int W_LOG       = 2,
  parameter int P_LOG       = 3,
  parameter int DATW        = 64,
  parameter int RUN_LINES   = 4,
  parameter int SENTINEL_EN = 1
) (
  input logic              CLK,
  input logic              RST,
  way_line_feeder_if.master bus
);
  localparam int WAYS  = 1 << W_LOG;
  localparam int LINEW = DATW << P_LOG;
  localparam int CNTW  = $clog2(RUN_LINES + 1);
  localparam logic [CNTW-1:0] RUN_MAX = CNTW'(RUN_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [W_LOG-1:0] rr, rr_nxt;
  logic [CNTW-1:0]  cnt     [WAYS];
  logic [CNTW-1:0]  cnt_nxt [WAYS];
  logic             real_line, real_nxt;
  logic             req, req_nxt;
  logic [W_LOG-1:0] req_way, req_way_nxt;
  logic [LINEW-1:0] dot, dot_nxt;
  logic             doten, doten_nxt;
  logic [W_LOG-1:0] waddr, waddr_nxt;
  logic             done, done_nxt;

  logic [WAYS-1:0]  eligible;
  logic             sel_found;
  logic [W_LOG-1:0] sel_way;
  logic [W_LOG-1:0] cand;
  logic             all_full;

  // Exhausted ways only compete for service when sentinel draining is on.
  always_comb begin
    eligible = '0;
    for (int w = 0; w < WAYS; w++) begin
      eligible[w] = bus.EMP[w] && ((cnt[w] < RUN_MAX) || (SENTINEL_EN != 0));
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_way   = '0;
    cand      = '0;
    for (int i = 0; i < WAYS; i++) begin
      cand = rr + W_LOG'(i);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_way   = cand;
      end
    end
  end

  always_comb begin
    all_full = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (cnt_nxt[w] != RUN_MAX) all_full = 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    cnt_nxt     = cnt;
    real_nxt    = real_line;
    req_nxt     = req;
    req_way_nxt = req_way;
    dot_nxt     = dot;
    doten_nxt   = 1'b0;
    waddr_nxt   = waddr;
    done_nxt    = done | all_full;

    unique case (state)
      S_IDLE: begin
        if (sel_found) begin
          if (cnt[sel_way] < RUN_MAX) begin
            req_nxt     = 1'b1;
            req_way_nxt = sel_way;
            real_nxt    = 1'b1;
            state_nxt   = S_REQ;
          end else begin
            dot_nxt   = '1;
            waddr_nxt = sel_way;
            doten_nxt = 1'b1;
            real_nxt  = 1'b0;
            state_nxt = S_WRITE;
          end
        end
      end
      S_REQ: begin
        if (bus.SRC_RDY) begin
          req_nxt   = 1'b0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.SRC_DINEN) begin
          dot_nxt   = bus.SRC_DIN;
          waddr_nxt = req_way;
          doten_nxt = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (real_line && (cnt[waddr] < RUN_MAX)) begin
          cnt_nxt[waddr] = cnt[waddr] + CNTW'(1);
        end
        rr_nxt    = waddr + W_LOG'(1);
        state_nxt = S_SETTLE;
      end
      // Gives the filler a cycle to drop EMP for the way just written.
      S_SETTLE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      rr        <= '0;
      real_line <= 1'b0;
      req       <= 1'b0;
      req_way   <= '0;
      dot       <= '0;
      doten     <= 1'b0;
      waddr     <= '0;
      done      <= 1'b0;
      for (int w = 0; w < WAYS; w++) cnt[w] <= '0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      real_line <= real_nxt;
      req       <= req_nxt;
      req_way   <= req_way_nxt;
      dot       <= dot_nxt;
      doten     <= doten_nxt;
      waddr     <= waddr_nxt;
      done      <= done_nxt;
      for (int w = 0; w < WAYS; w++) cnt[w] <= cnt_nxt[w];
    end
  end

  assign bus.SRC_REQ     = req;
  assign bus.SRC_REQ_WAY = req_way;
  assign bus.DOT         = dot;
  assign bus.DOTEN       = doten;
  assign bus.WADDR       = waddr;
  assign bus.DONE        = done;
endmodule
